// File: rtl/demosaic_pkg.sv
// Shared constants and helpers for the demosaicing datapath: carry-save
// widths, default tap/shift/pixel parameters and a constant-time clog2.
package demosaic_pkg;

  localparam int CS_W   = 12;
  localparam int PROD_W = CS_W + 1;

  localparam int N_TAPS_DEF = 4;
  localparam int SHIFT_DEF  = 2;
  localparam int OUT_W_DEF  = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cs_resolve_add.sv
// Carry-propagate resolution of a carry-save pair into a binary sum one bit
// wider than the inputs, so the result never truncates.
module cs_resolve_add
  import demosaic_pkg::*;
#(
  parameter int W = CS_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/cs_tap_accumulator.sv
// Accumulates N_TAPS resolved carry-save products, normalises by SHIFT and
// saturates to OUT_W. Define CS_TAP_ACC_ROUND_EN for round-half-up normalisation.
module cs_tap_accumulator
  import demosaic_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CS_W-1:0]  cs_a,
  input  logic [CS_W-1:0]  cs_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] pix_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat
);

  localparam int ACC_W  = PROD_W + clog2(N_TAPS);
  localparam int CNT_W  = clog2(N_TAPS);
  localparam int NORM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TAPS - 1);
  localparam logic [NORM_W-1:0] PIX_MAX  = NORM_W'({OUT_W{1'b1}});

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  pix_q, pix_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  total;
  logic [NORM_W-1:0] rounded;
  logic [NORM_W-1:0] norm;
  logic              accept;
  logic              last_accept;

  cs_resolve_add #(.W(CS_W)) u_resolve (
    .a_i   (cs_a),
    .b_i   (cs_b),
    .sum_o (prod)
  );

  assign total = acc_q + ACC_W'(prod);

`ifdef CS_TAP_ACC_ROUND_EN
  if (SHIFT > 0) begin : g_round
    assign rounded = {1'b0, total} + (NORM_W'(1) << (SHIFT - 1));
  end else begin : g_no_round
    assign rounded = {1'b0, total};
  end
`else
  assign rounded = {1'b0, total};
`endif

  assign norm = rounded >> SHIFT;

  // Valid/ready on both sides: a transfer happens on a rising edge where
  // valid && ready; the producer holds its data stable until that edge. A
  // tap may enter whenever the output slot is empty or draining this cycle.
  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready && !flush;
  assign last_accept = accept && (cnt_q == LAST_CNT);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last_accept) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = total;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // last_accept implies the slot is free, so a pending pixel is never overwritten
    if (last_accept) begin
      out_valid_d = 1'b1;
      if (norm > PIX_MAX) begin
        pix_d = '1;
        sat_d = 1'b1;
      end else begin
        pix_d = OUT_W'(norm);
        sat_d = 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      pix_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pix_out   = pix_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cs_tap_accumulator.sv
// Directed bench for cs_tap_accumulator: table of 4-tap groups plus hand-written
// sequences for backpressure, back-to-back throughput, reset and flush.
module tb_cs_tap_accumulator;
  import demosaic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cs_a, cs_b;
  logic        in_valid, in_ready, flush;
  logic [7:0]  pix_out;
  logic        out_valid, out_ready, sat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];  // {sat, pix}
  int         hs_cyc[$];
  logic [8:0] mon_e;

  typedef struct packed {
    logic [3:0][11:0] a;
    logic [3:0][11:0] b;
    logic [7:0]       pix;
    logic             sat;
  } vec_t;

  vec_t vecs[8];

  cs_tap_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_a      (cs_a),
    .cs_b      (cs_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every output handshake consumes one expected pixel
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pix=%0d sat=%0d expected none", pix_out, sat);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_out", int'(pix_out), int'(mon_e[7:0]));
        check("sat", int'(sat), int'(mon_e[8]));
      end
    end
  end

  // drivers
  task automatic send_tap(input logic [11:0] a, input logic [11:0] b);
    int budget;
    budget = 100;
    cs_a = a;
    cs_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL tap_accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic [3:0][11:0] a, input logic [3:0][11:0] b);
    for (int i = 0; i < 4; i++) send_tap(a[i], b[i]);
  endtask

  task automatic push_exp(input int pix, input int s);
    exp_q.push_back({1'(s), 8'(pix)});
  endtask

  task automatic wait_drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pix_out"}, int'(pix_out), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_sat"}, int'(sat), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int pix, input int s);
    vec_t r;
    int   p[4];
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      r.a[i] = 12'(p[i] / 2);
      r.b[i] = 12'(p[i] - p[i] / 2);
    end
    r.pix = 8'(pix);
    r.sat = 1'(s);
    return r;
  endfunction

  function automatic logic [3:0][11:0] rep(input int v);
    logic [3:0][11:0] r;
    for (int i = 0; i < 4; i++) r[i] = 12'(v);
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    cs_a = '0;
    cs_b = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;

    vecs[0] = mk(100, 200, 300, 400, 250, 0);
    vecs[1] = mk(3937, 3937, 3937, 3937, 255, 1);
`ifdef CS_TAP_ACC_ROUND_EN
    vecs[2] = mk(1, 1, 1, 0, 1, 0);
    vecs[6] = mk(255, 255, 256, 256, 255, 1);
    vecs[7] = mk(7, 0, 0, 0, 2, 0);
`else
    vecs[2] = mk(1, 1, 1, 0, 0, 0);
    vecs[6] = mk(255, 255, 256, 256, 255, 0);
    vecs[7] = mk(7, 0, 0, 0, 1, 0);
`endif
    vecs[3] = mk(8190, 8190, 8190, 8190, 255, 1);
    vecs[4] = mk(0, 0, 0, 0, 0, 0);
    vecs[5] = mk(255, 255, 255, 256, 255, 0);

    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table-driven groups with output-latency check
    for (int v = 0; v < 8; v++) begin
      check("idle_out_valid", int'(out_valid), 0);
      push_exp(int'(vecs[v].pix), int'(vecs[v].sat));
      send_group(vecs[v].a, vecs[v].b);
      @(negedge clk);
      check("latency_out_valid", int'(out_valid), 1);
      wait_drain();
    end

    // backpressure: pending pixel holds, held tap is neither lost nor doubled
    out_ready = 1'b0;
    push_exp(40, 0);
    send_group(rep(20), rep(20));
    cs_a = 12'd10;
    cs_b = 12'd10;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_pix_hold", int'(pix_out), 40);
      check("stall_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_exp(11, 0);
    for (int k = 0; k < 3; k++) send_tap(12'd4, 12'd4);
    wait_drain();

    // back-to-back groups: results exactly 4 cycles apart
    hs_cyc.delete();
    push_exp(250, 0);
    push_exp(100, 0);
    send_group(vecs[0].a, vecs[0].b);
    send_group(rep(50), rep(50));
    wait_drain();
    check("b2b_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("b2b_spacing", hs_cyc[1] - hs_cyc[0], 4);

    // reset mid-group
    send_tap(12'd250, 12'd250);
    send_tap(12'd250, 12'd250);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(4, 0);
    send_group(rep(2), rep(2));
    wait_drain();

    // flush leaves a pending result untouched
    out_ready = 1'b0;
    push_exp(60, 0);
    send_group(rep(30), rep(30));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_keeps_valid", int'(out_valid), 1);
    check("flush_keeps_pix", int'(pix_out), 60);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // flush mid-group, discarding the tap presented alongside it
    send_tap(12'd250, 12'd250);
    send_tap(12'd250, 12'd250);
    cs_a = 12'd500;
    cs_b = 12'd499;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    push_exp(4, 0);
    send_group(rep(2), rep(2));
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
